sram_addr_seq: RTL and testbench

Address-sequencing and strobe stage between the AVR control pins and the external SRAM. It deserialises a 21-bit SRAM address shifted in MSB-first on avr_si/avr_clk and holds it on sram_addr. On AVR read/write requests it generates timed sram_ce_n/sram_oe_n/sram_we_n strobes and post-increments the address. It feeds the system top, which steers sram_data between the AVR port and the SRAM using these strobes.

---
 rtl/sram_addr_seq.sv | 179 +++++++++++++++++
 tb/tb_sram_addr_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_addr_seq.sv
// SRAM address sequencer: deserialises the AVR address word, then drives
// timed ce/oe/we strobes and post-increments the address per access.
module sram_addr_seq #(
    parameter int unsigned ADDR_W     = 21,
    parameter int unsigned STROBE_CYC = 2,
    parameter bit          AUTO_INC   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              avr_clk,
    input  logic              avr_si,
    input  logic [2:0]        avr_ctrl,
    input  logic              avr_oe,
    input  logic              avr_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              busy,
    output logic              addr_loaded,
    output logic              req_err
);

    localparam int unsigned CNT_W = $clog2(ADDR_W + 1);
    localparam logic [2:0] MODE_SHIFT  = 3'b001;
    localparam logic [2:0] MODE_ACCESS = 3'b010;
    localparam logic [2:0] MODE_CLEAR  = 3'b111;
    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYC - 1);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WR_SU, S_WR, S_WR_HD, S_INC} state_t;

    state_t            state_q, state_d;
    logic [2:0]        clk_sync_q, clk_sync_d, oe_sync_q, oe_sync_d, we_sync_q, we_sync_d;
    logic [1:0]        si_sync_q, si_sync_d;
    logic [2:0]        ctrl1_q, ctrl1_d, ctrl2_q, ctrl2_d;
    logic [ADDR_W-2:0] shift_q, shift_d;
    logic [CNT_W-1:0]  bcnt_q, bcnt_d;
    logic [3:0]        scnt_q, scnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              clr_pend_q, clr_pend_d;
    logic              ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic              busy_q, busy_d, loaded_q, loaded_d, err_q, err_d;
    logic              clk_rise, oe_rise, we_rise, si, idle;

    assign clk_rise = clk_sync_q[1] & ~clk_sync_q[2];
    assign oe_rise  = oe_sync_q[1] & ~oe_sync_q[2];
    assign we_rise  = we_sync_q[1] & ~we_sync_q[2];
    assign si       = si_sync_q[1];
    assign idle     = (state_q == S_IDLE);

    always_comb begin
        clk_sync_d = {clk_sync_q[1:0], avr_clk};
        oe_sync_d  = {oe_sync_q[1:0], avr_oe};
        we_sync_d  = {we_sync_q[1:0], avr_we};
        si_sync_d  = {si_sync_q[0], avr_si};
        ctrl1_d    = avr_ctrl;
        ctrl2_d    = ctrl1_q;
        state_d    = state_q;
        shift_d    = shift_q;
        bcnt_d     = bcnt_q;
        scnt_d     = scnt_q;
        addr_d     = addr_q;
        clr_pend_d = clr_pend_q;
        loaded_d   = 1'b0;
        err_d      = 1'b0;

        if (ctrl2_q != MODE_SHIFT) begin
            bcnt_d = '0;
        end else if (clk_rise && idle) begin
            shift_d = {shift_q[ADDR_W-3:0], si};
            if (bcnt_q == CNT_W'(ADDR_W - 1)) begin
                addr_d   = {shift_q, si};
                loaded_d = 1'b1;
                bcnt_d   = '0;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end

        // A CLEAR seen mid-access is remembered and applied once back in IDLE.
        if (ctrl2_q == MODE_CLEAR && !idle) clr_pend_d = 1'b1;
        if (idle && (ctrl2_q == MODE_CLEAR || clr_pend_q)) begin
            addr_d     = '0;
            bcnt_d     = '0;
            clr_pend_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (ctrl2_q == MODE_ACCESS) begin
                    if (oe_rise && we_rise) begin
                        err_d = 1'b1;
                    end else if (oe_rise) begin
                        state_d = S_RD;
                        scnt_d  = STROBE_LAST;
                    end else if (we_rise) begin
                        state_d = S_WR_SU;
                    end
                end
            end
            S_RD: begin
                if (scnt_q == '0) state_d = S_INC;
                else              scnt_d  = scnt_q - 1'b1;
            end
            S_WR_SU: begin
                state_d = S_WR;
                scnt_d  = STROBE_LAST;
            end
            S_WR: begin
                if (scnt_q == '0) state_d = S_WR_HD;
                else              scnt_d  = scnt_q - 1'b1;
            end
            S_WR_HD: state_d = S_INC;
            S_INC: begin
                state_d = S_IDLE;
                if (AUTO_INC) addr_d = addr_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (!idle && (oe_rise || we_rise)) err_d = 1'b1;

        ce_n_d = !(state_d == S_RD || state_d == S_WR_SU || state_d == S_WR || state_d == S_WR_HD);
        oe_n_d = !(state_d == S_RD);
        we_n_d = !(state_d == S_WR);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            clk_sync_q <= '0;
            oe_sync_q  <= '0;
            we_sync_q  <= '0;
            si_sync_q  <= '0;
            ctrl1_q    <= '0;
            ctrl2_q    <= '0;
            shift_q    <= '0;
            bcnt_q     <= '0;
            scnt_q     <= '0;
            addr_q     <= '0;
            clr_pend_q <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            loaded_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_sync_q <= clk_sync_d;
            oe_sync_q  <= oe_sync_d;
            we_sync_q  <= we_sync_d;
            si_sync_q  <= si_sync_d;
            ctrl1_q    <= ctrl1_d;
            ctrl2_q    <= ctrl2_d;
            shift_q    <= shift_d;
            bcnt_q     <= bcnt_d;
            scnt_q     <= scnt_d;
            addr_q     <= addr_d;
            clr_pend_q <= clr_pend_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            busy_q     <= busy_d;
            loaded_q   <= loaded_d;
            err_q      <= err_d;
        end
    end

    assign sram_addr   = addr_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;
    assign busy        = busy_q;
    assign addr_loaded = loaded_q;
    assign req_err     = err_q;

endmodule

// File: tb/tb_sram_addr_seq.sv
// Randomised bench for sram_addr_seq against a transaction-level address model.
module tb_sram_addr_seq;

    localparam int unsigned ADDR_W = 21;
    localparam int unsigned SC     = 2;
    localparam logic [2:0] M_NOP = 3'b000, M_SHIFT = 3'b001, M_ACC = 3'b010, M_CLR = 3'b111;

    logic              clk = 1'b0, rst_n = 1'b0;
    logic              avr_clk = 1'b0, avr_si = 1'b0, avr_oe = 1'b0, avr_we = 1'b0;
    logic [2:0]        avr_ctrl = M_NOP;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_ce_n, sram_oe_n, sram_we_n, busy, addr_loaded, req_err;

    sram_addr_seq #(.ADDR_W(ADDR_W), .STROBE_CYC(SC), .AUTO_INC(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .avr_clk(avr_clk), .avr_si(avr_si), .avr_ctrl(avr_ctrl),
        .avr_oe(avr_oe), .avr_we(avr_we), .sram_addr(sram_addr), .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .busy(busy),
        .addr_loaded(addr_loaded), .req_err(req_err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [ADDR_W-1:0] exp_addr = '0;

    // Cumulative activity counters sampled on the falling edge.
    int cyc = 0, n_loaded = 0, n_err = 0, n_ce = 0, n_oe = 0, n_we = 0, n_busy = 0, n_hold = 0;
    int ce_fall = 0, ce_rise = 0, we_fall = 0, we_rise = 0;
    logic prev_ce = 1'b1, prev_we = 1'b1;
    logic [ADDR_W-1:0] prev_addr = '0;

    always @(negedge clk) begin
        cyc++;
        if (addr_loaded) n_loaded++;
        if (req_err)     n_err++;
        if (!sram_ce_n)  n_ce++;
        if (!sram_oe_n)  n_oe++;
        if (!sram_we_n)  n_we++;
        if (busy)        n_busy++;
        if (!sram_ce_n && !prev_ce && sram_addr != prev_addr) n_hold++;
        if (prev_ce && !sram_ce_n) ce_fall = cyc;
        if (!prev_ce && sram_ce_n) ce_rise = cyc;
        if (prev_we && !sram_we_n) we_fall = cyc;
        if (!prev_we && sram_we_n) we_rise = cyc;
        prev_ce   = sram_ce_n;
        prev_we   = sram_we_n;
        prev_addr = sram_addr;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input logic [2:0] m);
        avr_ctrl = m;
        tick(4);
    endtask

    task automatic shift_bits(input logic [ADDR_W-1:0] w, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            avr_si = w[i];
            tick(1);
            avr_clk = 1'b1;
            tick(4);
            avr_clk = 1'b0;
            tick(4);
        end
        tick(3);
    endtask

    task automatic load_addr(input logic [ADDR_W-1:0] w);
        int l0;
        set_mode(M_SHIFT);
        l0 = n_loaded;
        shift_bits(w, ADDR_W);
        exp_addr = w;
        check_eq("load_addr", 32'(sram_addr), 32'(exp_addr));
        check_eq("load_pulse", 32'(n_loaded - l0), 32'd1);
    endtask

    task automatic do_access(input bit wr);
        int ce0, oe0, we0, b0, e0, h0;
        set_mode(M_ACC);
        ce0 = n_ce; oe0 = n_oe; we0 = n_we; b0 = n_busy; e0 = n_err; h0 = n_hold;
        if (wr) avr_we = 1'b1; else avr_oe = 1'b1;
        tick(14);
        avr_we = 1'b0; avr_oe = 1'b0;
        tick(4);
        exp_addr = exp_addr + 1'b1;
        if (wr) begin
            check_eq("wr_we_cyc", 32'(n_we - we0), 32'(SC));
            check_eq("wr_ce_cyc", 32'(n_ce - ce0), 32'(SC + 2));
            check_eq("wr_oe_cyc", 32'(n_oe - oe0), 32'd0);
            check_eq("wr_busy", 32'(n_busy - b0), 32'(SC + 3));
            check_eq("wr_setup", 32'(we_fall - ce_fall), 32'd1);
            check_eq("wr_hold", 32'(ce_rise - we_rise), 32'd1);
        end else begin
            check_eq("rd_oe_cyc", 32'(n_oe - oe0), 32'(SC));
            check_eq("rd_ce_cyc", 32'(n_ce - ce0), 32'(SC));
            check_eq("rd_we_cyc", 32'(n_we - we0), 32'd0);
            check_eq("rd_busy", 32'(n_busy - b0), 32'(SC + 1));
        end
        check_eq("acc_err", 32'(n_err - e0), 32'd0);
        check_eq("acc_addr_hold", 32'(n_hold - h0), 32'd0);
        check_eq("acc_addr", 32'(sram_addr), 32'(exp_addr));
    endtask

    initial begin
        int e0, ce0, oe0, l0, k;
        bit seen;
        tick(3);
        @(negedge clk);
        check_eq("rst_addr", 32'(sram_addr), 32'd0);
        check_eq("rst_strobes", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
        check_eq("rst_flags", {29'd0, busy, addr_loaded, req_err}, 32'd0);
        rst_n = 1'b1;
        tick(2);

        load_addr(21'h1ABCDE);

        // Partial word discarded when mode leaves SHIFT.
        set_mode(M_SHIFT);
        l0 = n_loaded;
        shift_bits(21'($urandom), 10);
        check_eq("abort_no_load", 32'(n_loaded - l0), 32'd0);
        check_eq("abort_addr", 32'(sram_addr), 32'(exp_addr));
        set_mode(M_NOP);
        load_addr(21'h000055);

        load_addr(21'h000010);
        do_access(1'b0);
        load_addr(21'h1FFFFF);
        do_access(1'b1);
        check_eq("wrap_addr", 32'(sram_addr), 32'd0);

        // Simultaneous request edges.
        set_mode(M_ACC);
        e0 = n_err; ce0 = n_ce;
        avr_oe = 1'b1; avr_we = 1'b1;
        tick(10);
        avr_oe = 1'b0; avr_we = 1'b0;
        tick(4);
        check_eq("both_err", 32'(n_err - e0), 32'd1);
        check_eq("both_ce", 32'(n_ce - ce0), 32'd0);
        check_eq("both_addr", 32'(sram_addr), 32'(exp_addr));

        // Write edge arriving during a read.
        e0 = n_err; oe0 = n_oe;
        avr_oe = 1'b1;
        tick(1);
        avr_we = 1'b1;
        tick(10);
        avr_oe = 1'b0; avr_we = 1'b0;
        tick(4);
        exp_addr = exp_addr + 1'b1;
        check_eq("busy_err", 32'(n_err - e0), 32'd1);
        check_eq("busy_rd_oe", 32'(n_oe - oe0), 32'(SC));
        check_eq("busy_rd_addr", 32'(sram_addr), 32'(exp_addr));

        // Request outside ACCESS mode is silently ignored.
        set_mode(M_NOP);
        e0 = n_err; ce0 = n_ce;
        avr_oe = 1'b1;
        tick(10);
        avr_oe = 1'b0;
        tick(4);
        check_eq("nop_req_err", 32'(n_err - e0), 32'd0);
        check_eq("nop_req_ce", 32'(n_ce - ce0), 32'd0);

        for (int it = 0; it < 24; it++) begin
            k = $urandom_range(0, 3);
            case (k)
                0: load_addr(($urandom_range(0, 3) == 0) ? 21'h1FFFFF : 21'($urandom));
                1: do_access(1'b0);
                2: do_access(1'b1);
                default: begin
                    set_mode(M_CLR);
                    tick(2);
                    set_mode(M_NOP);
                    exp_addr = '0;
                    check_eq("clear_addr", 32'(sram_addr), 32'(exp_addr));
                end
            endcase
        end

        // Asynchronous reset in the middle of the write strobe.
        load_addr(21'h0ABCDE);
        set_mode(M_ACC);
        avr_we = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk);
            #2;
            if (!sram_we_n) seen = 1'b1;
        end
        check_eq("mid_wr_reached", 32'(seen), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_strobes", {30'd0, sram_we_n, sram_ce_n}, 32'd3);
        check_eq("mid_rst_addr", 32'(sram_addr), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        avr_we = 1'b0;
        avr_ctrl = M_NOP;
        tick(3);
        rst_n = 1'b1;
        exp_addr = '0;
        tick(6);
        check_eq("post_rst_addr", 32'(sram_addr), 32'(exp_addr));
        check_eq("post_rst_ce", 32'(sram_ce_n), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
